rvx_debug_command_encoder: RTL and testbench

// - Instruction-producing counterpart of the core decoder: turns one debug abstract register-access

---
 rtl/rvx_debug_command_encoder.sv | 148 ++++++++++++++
 tb/tb_rvx_debug_command_encoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rvx_debug_command_encoder.sv
// Debug abstract register-access command encoder: expands one command into a short
// stream of RV32I/Zicsr instruction words that the halted core executes via valid/ready.
module rvx_debug_command_encoder #(
   parameter logic [11:0] DSCRATCH0_ADDR = 12'h7B2,
   parameter logic [11:0] DSCRATCH1_ADDR = 12'h7B3,
   parameter int unsigned TEMP_REG       = 1,
   parameter bit          EMIT_EBREAK    = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_regno,
   input  logic        cmd_abort,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_word,
   output logic        cmd_done,
   output logic        cmd_error
);

   localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
   localparam logic [2:0]  F3_CSRRW   = 3'b001;
   localparam logic [2:0]  F3_CSRRS   = 3'b010;
   localparam logic [31:0] EBREAK     = 32'h00100073;
   localparam logic [4:0]  TEMP       = TEMP_REG[4:0];
   localparam logic [4:0]  X0         = 5'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EMIT   = 2'd1,
      FINISH = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic        write_q, write_d;
   logic        is_csr_q, is_csr_d;
   logic        illegal_q, illegal_d;
   logic [11:0] regno_q, regno_d;

   logic        req_is_csr;
   logic        req_is_gpr;
   logic [2:0]  seq_len;
   logic        last_step;
   logic        handshake;
   logic [31:0] word;

   function automatic logic [31:0] sys_instr(input logic [11:0] csr, input logic [4:0] rs1,
                                             input logic [2:0] f3, input logic [4:0] rd);
      return {csr, rs1, f3, rd, OPC_SYSTEM};
   endfunction

   assign req_is_csr = (cmd_regno[15:12] == 4'h0);
   assign req_is_gpr = (cmd_regno[15:5] == 11'h080);
   assign seq_len    = (is_csr_q ? 3'd4 : 3'd1) + (EMIT_EBREAK ? 3'd1 : 3'd0);
   assign last_step  = (step_q == seq_len - 3'd1);
   assign handshake  = (state_q == EMIT) && inst_ready;

   // CSR accesses park TEMP in dscratch1 so the core's GPR state survives the command.
   always_comb begin
      word = EBREAK;
      if (!is_csr_q) begin
         if (step_q == 3'd0) begin
            word = write_q ? sys_instr(DSCRATCH0_ADDR, X0, F3_CSRRS, regno_q[4:0])
                           : sys_instr(DSCRATCH0_ADDR, regno_q[4:0], F3_CSRRW, X0);
         end
      end else begin
         case (step_q)
            3'd0: word = sys_instr(DSCRATCH1_ADDR, TEMP, F3_CSRRW, X0);
            3'd1: word = write_q ? sys_instr(DSCRATCH0_ADDR, X0, F3_CSRRS, TEMP)
                                 : sys_instr(regno_q, X0, F3_CSRRS, TEMP);
            3'd2: word = write_q ? sys_instr(regno_q, TEMP, F3_CSRRW, X0)
                                 : sys_instr(DSCRATCH0_ADDR, TEMP, F3_CSRRW, X0);
            3'd3: word = sys_instr(DSCRATCH1_ADDR, X0, F3_CSRRS, TEMP);
            default: word = EBREAK;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      write_d   = write_q;
      is_csr_d  = is_csr_q;
      illegal_d = illegal_q;
      regno_d   = regno_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               write_d   = cmd_write;
               regno_d   = cmd_regno[11:0];
               is_csr_d  = req_is_csr;
               illegal_d = !(req_is_csr || req_is_gpr);
               step_d    = 3'd0;
               state_d   = (req_is_csr || req_is_gpr) ? EMIT : FINISH;
            end
         end
         EMIT: begin
            if (cmd_abort) begin
               state_d = IDLE;
               step_d  = 3'd0;
            end else if (handshake) begin
               if (last_step) begin
                  state_d = FINISH;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
            step_d  = 3'd0;
         end
         default: begin
            state_d = IDLE;
            step_d  = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         step_q    <= 3'd0;
         write_q   <= 1'b0;
         is_csr_q  <= 1'b0;
         illegal_q <= 1'b0;
         regno_q   <= 12'h000;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         write_q   <= write_d;
         is_csr_q  <= is_csr_d;
         illegal_q <= illegal_d;
         regno_q   <= regno_d;
      end
   end

   // An abort landing in FINISH suppresses the completion pulse.
   assign cmd_ready  = (state_q == IDLE);
   assign inst_valid = (state_q == EMIT);
   assign inst_word  = inst_valid ? word : 32'h0000_0000;
   assign cmd_done   = (state_q == FINISH) && !cmd_abort;
   assign cmd_error  = cmd_done && illegal_q;

endmodule

// File: tb/tb_rvx_debug_command_encoder.sv
// Directed self-checking bench for rvx_debug_command_encoder: hand-encoded instruction
// words checked for GPR/CSR reads and writes, stalls, illegal regno, abort and reset.
module tb_rvx_debug_command_encoder;

   logic        clock;
   logic        reset_n;
   logic        cmdValid;
   logic        cmdReady;
   logic        cmdWrite;
   logic [15:0] cmdRegno;
   logic        cmdAbort;
   logic        instValid;
   logic        instReady;
   logic [31:0] instWord;
   logic        cmdDone;
   logic        cmdError;

   int checkCount;
   int passCount;
   logic [31:0] expWords [0:4];

   localparam logic [31:0] EBREAK = 32'h00100073;

   rvx_debug_command_encoder dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .cmd_valid  (cmdValid),
      .cmd_ready  (cmdReady),
      .cmd_write  (cmdWrite),
      .cmd_regno  (cmdRegno),
      .cmd_abort  (cmdAbort),
      .inst_valid (instValid),
      .inst_ready (instReady),
      .inst_word  (instWord),
      .cmd_done   (cmdDone),
      .cmd_error  (cmdError)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   // Presents one command at a negedge; returns at the next negedge, after acceptance.
   task automatic applyStimulus(input logic wr, input logic [15:0] regno);
      cmdValid = 1'b1;
      cmdWrite = wr;
      cmdRegno = regno;
      #1;
      checkOutput("cmd_ready_idle", {31'd0, cmdReady}, 32'd1);
      @(negedge clock);
      cmdValid = 1'b0;
      cmdWrite = 1'b0;
      cmdRegno = 16'h0000;
   endtask

   // Consumes n words with inst_ready high, then expects the done pulse and return to idle.
   task automatic expectSequence(input string tag, input int n);
      instReady = 1'b1;
      for (int i = 0; i < n; i++) begin
         checkOutput({tag, "_valid"}, {31'd0, instValid}, 32'd1);
         checkOutput({tag, "_word"}, instWord, expWords[i]);
         checkOutput({tag, "_busy"}, {31'd0, cmdReady}, 32'd0);
         @(negedge clock);
      end
      checkOutput({tag, "_done"}, {31'd0, cmdDone}, 32'd1);
      checkOutput({tag, "_noerr"}, {31'd0, cmdError}, 32'd0);
      checkOutput({tag, "_fin_novalid"}, {31'd0, instValid}, 32'd0);
      @(negedge clock);
      checkOutput({tag, "_ready_back"}, {31'd0, cmdReady}, 32'd1);
      checkOutput({tag, "_done_once"}, {31'd0, cmdDone}, 32'd0);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset_n    = 1'b0;
      cmdValid   = 1'b0;
      cmdWrite   = 1'b0;
      cmdRegno   = 16'h0000;
      cmdAbort   = 1'b0;
      instReady  = 1'b0;
      #12;
      checkOutput("rst_cmd_ready", {31'd0, cmdReady}, 32'd1);
      checkOutput("rst_inst_valid", {31'd0, instValid}, 32'd0);
      checkOutput("rst_inst_word", instWord, 32'h0);
      checkOutput("rst_cmd_done", {31'd0, cmdDone}, 32'd0);
      checkOutput("rst_cmd_error", {31'd0, cmdError}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // GPR read x5: one data word plus EBREAK
      applyStimulus(1'b0, 16'h1005);
      expWords[0] = 32'h7B229073;
      expWords[1] = EBREAK;
      expectSequence("gpr_rd_x5", 2);

      // GPR write x7 with a stalled core: word must hold until accepted
      instReady = 1'b0;
      applyStimulus(1'b1, 16'h1007);
      instReady = 1'b0;
      checkOutput("gpr_wr_x7_w0", instWord, 32'h7B2023F3);
      @(negedge clock);
      checkOutput("gpr_wr_x7_hold_valid", {31'd0, instValid}, 32'd1);
      checkOutput("gpr_wr_x7_hold", instWord, 32'h7B2023F3);
      @(negedge clock);
      checkOutput("gpr_wr_x7_hold2", instWord, 32'h7B2023F3);
      instReady = 1'b1;
      @(negedge clock);
      instReady = 1'b0;
      checkOutput("gpr_wr_x7_ebreak_stall", instWord, EBREAK);
      @(negedge clock);
      checkOutput("gpr_wr_x7_ebreak_hold", instWord, EBREAK);
      checkOutput("gpr_wr_x7_nodone", {31'd0, cmdDone}, 32'd0);
      expWords[0] = EBREAK;
      expectSequence("gpr_wr_x7_tail", 1);

      // CSR read 0x300: full dscratch1 save/restore wrapper
      applyStimulus(1'b0, 16'h0300);
      expWords[0] = 32'h7B309073;
      expWords[1] = 32'h300020F3;
      expWords[2] = 32'h7B209073;
      expWords[3] = 32'h7B3020F3;
      expWords[4] = EBREAK;
      expectSequence("csr_rd_300", 5);

      // Boundaries: GPR write to x0 and GPR read of x31
      applyStimulus(1'b1, 16'h1000);
      expWords[0] = 32'h7B202073;
      expWords[1] = EBREAK;
      expectSequence("gpr_wr_x0", 2);
      applyStimulus(1'b0, 16'h101F);
      expWords[0] = 32'h7B2F9073;
      expWords[1] = EBREAK;
      expectSequence("gpr_rd_x31", 2);

      // Illegal regnos: no words, done+error for one cycle
      applyStimulus(1'b0, 16'h2000);
      checkOutput("ill_2000_novalid", {31'd0, instValid}, 32'd0);
      checkOutput("ill_2000_done", {31'd0, cmdDone}, 32'd1);
      checkOutput("ill_2000_error", {31'd0, cmdError}, 32'd1);
      @(negedge clock);
      checkOutput("ill_2000_ready", {31'd0, cmdReady}, 32'd1);
      checkOutput("ill_2000_error_once", {31'd0, cmdError}, 32'd0);
      applyStimulus(1'b1, 16'h1020);
      checkOutput("ill_1020_error", {31'd0, cmdError}, 32'd1);
      @(negedge clock);

      // CSR write 0x341 aborted after the second word is consumed
      instReady = 1'b1;
      applyStimulus(1'b1, 16'h0341);
      checkOutput("abort_w0", instWord, 32'h7B309073);
      @(negedge clock);
      checkOutput("abort_w1", instWord, 32'h7B2020F3);
      @(negedge clock);
      instReady = 1'b0;
      cmdAbort  = 1'b1;
      #1;
      checkOutput("abort_w2", instWord, 32'h34109073);
      @(negedge clock);
      cmdAbort = 1'b0;
      #1;
      checkOutput("abort_novalid", {31'd0, instValid}, 32'd0);
      checkOutput("abort_nodone", {31'd0, cmdDone}, 32'd0);
      checkOutput("abort_idle", {31'd0, cmdReady}, 32'd1);
      @(negedge clock);
      checkOutput("abort_nodone_later", {31'd0, cmdDone}, 32'd0);

      // Reset in the middle of a CSR read
      instReady = 1'b1;
      applyStimulus(1'b0, 16'h0300);
      @(negedge clock);
      checkOutput("rstmid_w1", instWord, 32'h300020F3);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("rstmid_ready", {31'd0, cmdReady}, 32'd1);
      checkOutput("rstmid_valid", {31'd0, instValid}, 32'd0);
      checkOutput("rstmid_word", instWord, 32'h0);
      checkOutput("rstmid_done", {31'd0, cmdDone}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      applyStimulus(1'b0, 16'h1001);
      expWords[0] = 32'h7B209073;
      expWords[1] = EBREAK;
      expectSequence("post_rst_gpr_rd_x1", 2);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
